// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcode classes, next-PC select encodings and
// the multi-cycle controller state type.
// Optional build macro: CTRL_TRAP_EN (adds the TRAP state).
package riscv_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [1:0] PC_SEL_PLUS4 = 2'd0;
  localparam logic [1:0] PC_SEL_IMM   = 2'd1;
  localparam logic [1:0] PC_SEL_ALU   = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5
`ifdef CTRL_TRAP_EN
    ,
    ST_TRAP   = 3'd6
`endif
  } ctrl_state_t;

endpackage

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer for the RV32I core: drives the shared memory
// port, IR load, PC update and register-file write, and counts retired
// instructions.
// Optional build macro: CTRL_TRAP_EN (illegal opcodes park the FSM in TRAP
// instead of executing as NOPs).
module multicycle_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [6:0]       opcode,
  input  logic             brc_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             rf_we,
  output logic             trap,
  output logic [CNT_W-1:0] instret
);

  ctrl_state_t state, state_nxt;
  logic        retire;

  // State register; reset drops any in-flight memory request immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode with Moore memory outputs and single-cycle strobes.
  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_sel   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = PC_SEL_PLUS4;
    rf_we     = 1'b0;
    trap      = 1'b0;
    retire    = 1'b0;
    case (state)
      ST_IDLE: state_nxt = ST_FETCH;
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we     = 1'b1;
          state_nxt = ST_DECODE;
        end
      end
      ST_DECODE: state_nxt = ST_EXEC;
      ST_EXEC: begin
        case (opcode)
          OP_BRANCH: begin
            pc_we     = 1'b1;
            pc_sel    = brc_taken ? PC_SEL_IMM : PC_SEL_PLUS4;
            retire    = 1'b1;
            state_nxt = ST_FETCH;
          end
          OP_LOAD, OP_STORE: state_nxt = ST_MEM;
          OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_REG:
            state_nxt = ST_WB;
          default: begin
`ifdef CTRL_TRAP_EN
            state_nxt = ST_TRAP;
`else
            pc_we     = 1'b1;
            retire    = 1'b1;
            state_nxt = ST_FETCH;
`endif
          end
        endcase
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_sel = 1'b1;
        mem_we  = (opcode == OP_STORE);
        if (mem_ready) begin
          if (opcode == OP_STORE) begin
            pc_we     = 1'b1;
            retire    = 1'b1;
            state_nxt = ST_FETCH;
          end else begin
            state_nxt = ST_WB;
          end
        end
      end
      ST_WB: begin
        rf_we     = 1'b1;
        pc_we     = 1'b1;
        retire    = 1'b1;
        state_nxt = ST_FETCH;
        if (opcode == OP_JAL)       pc_sel = PC_SEL_IMM;
        else if (opcode == OP_JALR) pc_sel = PC_SEL_ALU;
      end
`ifdef CTRL_TRAP_EN
      ST_TRAP: trap = 1'b1;
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Retired-instruction counter; wraps silently.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    instret <= '0;
    else if (retire) instret <= instret + CNT_W'(1);
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected outputs are queued
// as stimulus is applied and compared once the DUT outputs settle.
// Optional build macro: CTRL_TRAP_EN (selects the illegal-opcode expectations).
module tb_multicycle_ctrl;

  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] IMMOP  = 7'b0010011;
  localparam logic [6:0] ILLEG  = 7'b1111111;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic       brc_taken = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, mem_sel, ir_we, pc_we, rf_we, trap;
  logic [1:0] pc_sel;
  logic [2:0] instret;

  typedef struct {
    logic       req, we, sel, ir, pcwe;
    logic [1:0] pcsel;
    logic       rf, trp;
    logic [2:0] ret;
    string      tag;
  } exp_t;

  exp_t       sb[$];
  logic [2:0] n_ret = 3'd0;
  int         checks = 0;
  int         errors = 0;

  multicycle_ctrl #(.CNT_W(3)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .brc_taken(brc_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_sel(mem_sel), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .rf_we(rf_we), .trap(trap), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input string fld, input logic [2:0] got,
                     input logic [2:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s.%s got %0h exp %0h", tag, fld, got, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    e = sb.pop_front();
    cmp(e.tag, "mem_req", {2'b0, mem_req}, {2'b0, e.req});
    cmp(e.tag, "mem_we",  {2'b0, mem_we},  {2'b0, e.we});
    cmp(e.tag, "mem_sel", {2'b0, mem_sel}, {2'b0, e.sel});
    cmp(e.tag, "ir_we",   {2'b0, ir_we},   {2'b0, e.ir});
    cmp(e.tag, "pc_we",   {2'b0, pc_we},   {2'b0, e.pcwe});
    cmp(e.tag, "pc_sel",  {1'b0, pc_sel},  {1'b0, e.pcsel});
    cmp(e.tag, "rf_we",   {2'b0, rf_we},   {2'b0, e.rf});
    cmp(e.tag, "trap",    {2'b0, trap},    {2'b0, e.trp});
    cmp(e.tag, "instret", instret,         e.ret);
  endtask

  // One clock window: drive inputs at the falling edge, queue expectation,
  // compare once outputs settle. A pc_we strobe marks a retiring cycle.
  task automatic step(input logic rn, input logic [6:0] opc, input logic brc,
                      input logic rdy, input logic req, input logic we,
                      input logic sel, input logic ir, input logic pcwe,
                      input logic [1:0] pcsel, input logic rf, input logic trp,
                      input string tag);
    exp_t e;
    @(negedge clk);
    reset_n = rn; opcode = opc; brc_taken = brc; mem_ready = rdy;
    if (!rn) n_ret = 3'd0;
    e.req = req; e.we = we; e.sel = sel; e.ir = ir; e.pcwe = pcwe;
    e.pcsel = pcsel; e.rf = rf; e.trp = trp; e.ret = n_ret; e.tag = tag;
    sb.push_back(e);
    if (pcwe) n_ret = n_ret + 3'd1;
    #1;
    check_out();
  endtask

  initial begin
    // reset, then release with IMM_OP and zero-wait memory
    step(0, IMMOP, 0, 1, 0,0,0,0,0,2'd0,0,0, "rst");
    step(1, IMMOP, 0, 1, 0,0,0,0,0,2'd0,0,0, "imm_idle");
    step(1, IMMOP, 0, 1, 1,0,0,1,0,2'd0,0,0, "imm_fetch");
    step(1, IMMOP, 0, 0, 0,0,0,0,0,2'd0,0,0, "imm_dec");
    step(1, IMMOP, 0, 0, 0,0,0,0,0,2'd0,0,0, "imm_exec");
    step(1, IMMOP, 0, 1, 0,0,0,0,1,2'd0,1,0, "imm_wb");
    // LOAD with two wait cycles in MEM
    step(1, LOAD, 0, 1, 1,0,0,1,0,2'd0,0,0, "ld_fetch");
    step(1, LOAD, 0, 1, 0,0,0,0,0,2'd0,0,0, "ld_dec");
    step(1, LOAD, 0, 1, 0,0,0,0,0,2'd0,0,0, "ld_exec");
    step(1, LOAD, 0, 0, 1,0,1,0,0,2'd0,0,0, "ld_mem0");
    step(1, LOAD, 0, 0, 1,0,1,0,0,2'd0,0,0, "ld_mem1");
    step(1, LOAD, 0, 1, 1,0,1,0,0,2'd0,0,0, "ld_mem2");
    step(1, LOAD, 0, 0, 0,0,0,0,1,2'd0,1,0, "ld_wb");
    // BRANCH taken then not taken
    step(1, BRANCH, 0, 1, 1,0,0,1,0,2'd0,0,0, "bt_fetch");
    step(1, BRANCH, 1, 1, 0,0,0,0,0,2'd0,0,0, "bt_dec");
    step(1, BRANCH, 1, 0, 0,0,0,0,1,2'd1,0,0, "bt_exec");
    step(1, BRANCH, 0, 1, 1,0,0,1,0,2'd0,0,0, "bn_fetch");
    step(1, BRANCH, 0, 0, 0,0,0,0,0,2'd0,0,0, "bn_dec");
    step(1, BRANCH, 0, 0, 0,0,0,0,1,2'd0,0,0, "bn_exec");
    // JAL with one fetch wait cycle, then JALR
    step(1, JAL, 0, 0, 1,0,0,0,0,2'd0,0,0, "jal_fwait");
    step(1, JAL, 0, 1, 1,0,0,1,0,2'd0,0,0, "jal_fetch");
    step(1, JAL, 0, 0, 0,0,0,0,0,2'd0,0,0, "jal_dec");
    step(1, JAL, 0, 0, 0,0,0,0,0,2'd0,0,0, "jal_exec");
    step(1, JAL, 0, 0, 0,0,0,0,1,2'd1,1,0, "jal_wb");
    step(1, JALR, 0, 1, 1,0,0,1,0,2'd0,0,0, "jalr_fetch");
    step(1, JALR, 0, 1, 0,0,0,0,0,2'd0,0,0, "jalr_dec");
    step(1, JALR, 0, 1, 0,0,0,0,0,2'd0,0,0, "jalr_exec");
    step(1, JALR, 0, 1, 0,0,0,0,1,2'd2,1,0, "jalr_wb");
    // zero-wait STORE (instret reaches 7), then LUI wraps the 3-bit counter
    step(1, STORE, 0, 1, 1,0,0,1,0,2'd0,0,0, "st_fetch");
    step(1, STORE, 0, 1, 0,0,0,0,0,2'd0,0,0, "st_dec");
    step(1, STORE, 0, 1, 0,0,0,0,0,2'd0,0,0, "st_exec");
    step(1, STORE, 0, 1, 1,1,1,0,1,2'd0,0,0, "st_mem");
    step(1, LUI, 0, 1, 1,0,0,1,0,2'd0,0,0, "lui_fetch");
    step(1, LUI, 0, 1, 0,0,0,0,0,2'd0,0,0, "lui_dec");
    step(1, LUI, 0, 1, 0,0,0,0,0,2'd0,0,0, "lui_exec");
    step(1, LUI, 0, 1, 0,0,0,0,1,2'd0,1,0, "lui_wb");
    step(1, LUI, 0, 0, 1,0,0,0,0,2'd0,0,0, "wrap_fetch");
    // STORE stalled in MEM, reset asserted mid-handshake
    step(1, STORE, 0, 1, 1,0,0,1,0,2'd0,0,0, "sr_fetch");
    step(1, STORE, 0, 1, 0,0,0,0,0,2'd0,0,0, "sr_dec");
    step(1, STORE, 0, 0, 0,0,0,0,0,2'd0,0,0, "sr_exec");
    step(1, STORE, 0, 0, 1,1,1,0,0,2'd0,0,0, "sr_memwait");
    step(0, STORE, 0, 1, 0,0,0,0,0,2'd0,0,0, "sr_rst");
    step(0, STORE, 0, 1, 0,0,0,0,0,2'd0,0,0, "sr_rsthold");
    step(1, ILLEG, 0, 1, 0,0,0,0,0,2'd0,0,0, "re_idle");
    step(1, ILLEG, 0, 1, 1,0,0,1,0,2'd0,0,0, "il_fetch");
    step(1, ILLEG, 0, 1, 0,0,0,0,0,2'd0,0,0, "il_dec");
`ifdef CTRL_TRAP_EN
    step(1, ILLEG, 0, 1, 0,0,0,0,0,2'd0,0,0, "il_exec");
    for (int i = 0; i < 4; i++)
      step(1, ILLEG, 0, 1, 0,0,0,0,0,2'd0,0,1, "il_trap");
`else
    step(1, ILLEG, 0, 1, 0,0,0,0,1,2'd0,0,0, "il_exec");
    step(1, IMMOP, 0, 0, 1,0,0,0,0,2'd0,0,0, "il_refetch");
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
